// File: rtl/logic_result_buffer_pkg.sv
// Shared definitions for the logic-unit result buffer.
//   LOGIC_WIDTH : default operand/result width of the 4-bit logic unit
//   FLAG_*      : bit positions of the status flags stored with each result
//   FLAG_W      : number of flag bits
package logic_result_buffer_pkg;

    localparam int LOGIC_WIDTH  = 4;

    localparam int FLAG_ZERO    = 0;
    localparam int FLAG_PARITY  = 1;
    localparam int FLAG_ALLONES = 2;
    localparam int FLAG_W       = 3;

    typedef logic [FLAG_W-1:0] flags_t;

endpackage

// File: rtl/logic_result_buffer_result_flags.sv
// result_flags: combinational status-flag generator for a logic-unit result.
// Ports:
//   result_i [WIDTH-1:0]  result word from the logic unit
//   flags_o  [FLAG_W-1:0] {allones, parity (1 = odd ones), zero}
module result_flags
    import logic_result_buffer_pkg::*;
#(
    parameter int WIDTH = LOGIC_WIDTH
) (
    input  logic [WIDTH-1:0]  result_i,
    output logic [FLAG_W-1:0] flags_o
);

    always_comb begin
        flags_o               = '0;
        flags_o[FLAG_ZERO]    = (result_i == '0);
        flags_o[FLAG_PARITY]  = ^result_i;
        flags_o[FLAG_ALLONES] = &result_i;
    end

endmodule

// File: rtl/logic_result_buffer.sv
// logic_result_buffer: registered FIFO stage after the combinational logic unit.
// Captures results on a valid/ready handshake, tags them with status flags and
// presents them in order to the writeback/display stage.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   flush                 synchronous clear of FIFO contents (op_count kept)
//   in_valid/in_ready     producer handshake; in_ready = !full (registered only)
//   in_result             result from the logic unit
//   out_valid/out_ready   consumer handshake for the head entry
//   out_result, out_flags head entry and its {allones, parity, zero} flags
//   level                 occupancy 0..DEPTH
//   op_count              accepted pushes since reset, wraps
module logic_result_buffer
    import logic_result_buffer_pkg::*;
#(
    parameter int WIDTH     = LOGIC_WIDTH,
    parameter int DEPTH     = 2,
    parameter int CNT_WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_result,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_result,
    output logic [FLAG_W-1:0]          out_flags,
    output logic [$clog2(DEPTH):0]     level,
    output logic [CNT_WIDTH-1:0]       op_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = $clog2(DEPTH) + 1;
    localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);
    localparam logic [LVL_W-1:0] LVL_ONE  = LVL_W'(1);

    logic [WIDTH-1:0]     res_mem_q  [DEPTH];
    logic [FLAG_W-1:0]    flag_mem_q [DEPTH];

    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]     level_q, level_d;
    logic [CNT_WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0]     out_result_q, out_result_d;
    logic [FLAG_W-1:0]    out_flags_q, out_flags_d;

    logic [FLAG_W-1:0]    in_flags;
    logic                 push;
    logic                 pop;
    logic                 empty_after_pop;

    result_flags #(.WIDTH(WIDTH)) u_flags (
        .result_i (in_result),
        .flags_o  (in_flags)
    );

    assign in_ready   = (level_q != LVL_FULL);
    assign out_valid  = (level_q != '0);
    assign push       = in_valid & in_ready;
    assign pop        = out_valid & out_ready;
    assign level      = level_q;
    assign op_count   = count_q;
    assign out_result = out_result_q;
    assign out_flags  = out_flags_q;

    // True when nothing older than this cycle's push will remain, so the
    // pushed word itself becomes the new head.
    assign empty_after_pop = (level_q == '0) || (pop && (level_q == LVL_ONE));

    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        level_d      = level_q;
        count_d      = count_q;
        out_result_d = out_result_q;
        out_flags_d  = out_flags_q;

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
                count_d  = count_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   level_d = level_q + 1'b1;
                2'b01:   level_d = level_q - 1'b1;
                default: level_d = level_q;
            endcase
            // The head is held in its own register so it keeps its last value
            // once the FIFO drains; refresh it only when a head will exist.
            if (level_d != '0) begin
                if (empty_after_pop) begin
                    out_result_d = in_result;
                    out_flags_d  = in_flags;
                end else begin
                    out_result_d = res_mem_q[rd_ptr_d];
                    out_flags_d  = flag_mem_q[rd_ptr_d];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush) begin
            res_mem_q[wr_ptr_q]  <= in_result;
            flag_mem_q[wr_ptr_q] <= in_flags;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            level_q      <= '0;
            count_q      <= '0;
            out_result_q <= '0;
            out_flags_q  <= '0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            level_q      <= level_d;
            count_q      <= count_d;
            out_result_q <= out_result_d;
            out_flags_q  <= out_flags_d;
        end
    end

endmodule

// File: tb/tb_logic_result_buffer.sv
// Directed testbench for logic_result_buffer (DEPTH=2, CNT_WIDTH=8) plus a
// second instance with CNT_WIDTH=2 for counter wrap.
module tb_logic_result_buffer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       flush = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [3:0] in_result = 4'h0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [3:0] out_result;
    logic [2:0] out_flags;
    logic [1:0] level;
    logic [7:0] op_count;

    logic       in_valid2 = 1'b0;
    logic       in_ready2;
    logic [3:0] in_result2 = 4'h0;
    logic       out_valid2;
    logic       out_ready2 = 1'b0;
    logic [3:0] out_result2;
    logic [2:0] out_flags2;
    logic [1:0] level2;
    logic [1:0] op_count2;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    logic_result_buffer #(.WIDTH(4), .DEPTH(2), .CNT_WIDTH(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_result  (in_result),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_flags  (out_flags),
        .level      (level),
        .op_count   (op_count)
    );

    logic_result_buffer #(.WIDTH(4), .DEPTH(2), .CNT_WIDTH(2)) dut2 (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (1'b0),
        .in_valid   (in_valid2),
        .in_ready   (in_ready2),
        .in_result  (in_result2),
        .out_valid  (out_valid2),
        .out_ready  (out_ready2),
        .out_result (out_result2),
        .out_flags  (out_flags2),
        .level      (level2),
        .op_count   (op_count2)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock edge; outputs are sampled 1 time unit after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [2:0] exp_flags(input logic [3:0] v);
        return {(v == 4'hF), (($countones(v) % 2) == 1), (v == 4'h0)};
    endfunction

    initial begin
        logic [3:0] d;

        // Reset state
        #12;
        check("rst_level", 32'(level), 0);
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_in_ready", 32'(in_ready), 1);
        check("rst_op_count", 32'(op_count), 0);
        check("rst_out_result", 32'(out_result), 0);
        check("rst_out_flags", 32'(out_flags), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // 1: single push of 0001
        in_valid = 1'b1; in_result = 4'b0001;
        step();
        in_valid = 1'b0;
        check("t1_out_valid", 32'(out_valid), 1);
        check("t1_out_result", 32'(out_result), 32'h1);
        check("t1_out_flags", 32'(out_flags), 32'b010);
        check("t1_level", 32'(level), 1);
        check("t1_op_count", 32'(op_count), 1);

        // Async reset pulse between edges clears everything
        rst_n = 1'b0;
        #1;
        check("t1r_level", 32'(level), 0);
        check("t1r_op_count", 32'(op_count), 0);
        check("t1r_out_result", 32'(out_result), 0);
        #1;
        rst_n = 1'b1;

        // 2: fill with 1101, 0000; third in_valid is refused
        out_ready = 1'b0;
        in_valid = 1'b1; in_result = 4'b1101;
        step();
        check("t2_head_a", 32'(out_result), 32'hD);
        in_result = 4'b0000;
        step();
        check("t2_level", 32'(level), 2);
        check("t2_in_ready", 32'(in_ready), 0);
        check("t2_head", 32'(out_result), 32'hD);
        check("t2_flags", 32'(out_flags), 32'b010);
        in_result = 4'b1111;
        step();
        check("t2_level_full", 32'(level), 2);
        check("t2_op_count", 32'(op_count), 2);
        check("t2_head_stable", 32'(out_result), 32'hD);

        // 3: full with pop and in_valid: only pop
        out_ready = 1'b1;
        step();
        check("t3_level", 32'(level), 1);
        check("t3_in_ready", 32'(in_ready), 1);
        check("t3_op_count", 32'(op_count), 2);
        check("t3_head", 32'(out_result), 32'h0);
        check("t3_head_flags", 32'(out_flags), 32'b001);
        out_ready = 1'b0;
        step();
        check("t3_push_level", 32'(level), 2);
        check("t3_push_count", 32'(op_count), 3);
        in_valid = 1'b0;
        out_ready = 1'b1;
        step();
        check("t3_head2", 32'(out_result), 32'hF);
        check("t3_head2_flags", 32'(out_flags), 32'b100);
        step();
        check("t3_empty_valid", 32'(out_valid), 0);
        check("t3_empty_level", 32'(level), 0);
        check("t3_hold_result", 32'(out_result), 32'hF);
        step();
        check("t3_pop_empty_level", 32'(level), 0);

        // 4: streaming 20 words, data 0..15 then wrap
        in_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            d = 4'(i % 16);
            in_result = d;
            step();
            check($sformatf("t4_data%0d", i), 32'(out_result), 32'(d));
            check($sformatf("t4_flags%0d", i), 32'(out_flags), 32'(exp_flags(d)));
            check($sformatf("t4_level%0d", i), 32'(level), 1);
        end
        in_valid = 1'b0;
        step();
        check("t4_drain_level", 32'(level), 0);
        check("t4_op_count", 32'(op_count), 23);

        // 5: flush with two entries buffered and in_valid high
        out_ready = 1'b0;
        in_valid = 1'b1; in_result = 4'b0101;
        step();
        in_result = 4'b1010;
        step();
        check("t5_level_pre", 32'(level), 2);
        flush = 1'b1; in_result = 4'b0111;
        step();
        flush = 1'b0; in_valid = 1'b0;
        check("t5_level", 32'(level), 0);
        check("t5_out_valid", 32'(out_valid), 0);
        check("t5_op_count", 32'(op_count), 25);
        check("t5_in_ready", 32'(in_ready), 1);
        // flush discards a push that in_ready would otherwise allow
        in_valid = 1'b1; in_result = 4'b0110;
        step();
        check("t5_head", 32'(out_result), 32'h6);
        check("t5_count2", 32'(op_count), 26);
        flush = 1'b1; in_result = 4'b0011;
        step();
        flush = 1'b0;
        check("t5b_level", 32'(level), 0);
        check("t5b_op_count", 32'(op_count), 26);

        // 6: async reset with entries buffered
        in_result = 4'b1000;
        step();
        in_result = 4'b0100;
        step();
        in_valid = 1'b0;
        check("t6_level_pre", 32'(level), 2);
        check("t6_head_pre", 32'(out_result), 32'h8);
        check("t6_count_pre", 32'(op_count), 28);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_out_valid", 32'(out_valid), 0);
        check("t6_level", 32'(level), 0);
        check("t6_op_count", 32'(op_count), 0);
        check("t6_in_ready", 32'(in_ready), 1);
        @(negedge clk);
        rst_n = 1'b1;

        // CNT_WIDTH=2 wrap: 5 pushes -> 1
        in_valid2 = 1'b1; in_result2 = 4'b0011; out_ready2 = 1'b1;
        for (int i = 0; i < 4; i++) step();
        check("w_count4", 32'(op_count2), 0);
        step();
        check("w_count5", 32'(op_count2), 1);
        check("w_level", 32'(level2), 1);
        check("w_out_valid", 32'(out_valid2), 1);
        check("w_in_ready", 32'(in_ready2), 1);
        check("w_result", 32'(out_result2), 32'h3);
        check("w_flags", 32'(out_flags2), 32'b000);
        in_valid2 = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
